// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake
// matching the shift-add multiplier so both can share one arithmetic control path.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             done,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] dvd_reg, dvd_next;
    logic [WIDTH-1:0] divisor_reg, divisor_next;
    // The settled remainder is always below the divisor, so only the shifted
    // trial value needs the extra (WIDTH+1)th bit.
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] r_reg, r_next;
    logic             done_reg, done_next;
    logic             busy_reg, busy_next;
    logic             dbz_reg, dbz_next;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_sub;
    logic [WIDTH-1:0] rem_new;
    logic [WIDTH-1:0] dvd_new;
    logic             fits;

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    assign rem_shift = {rem_reg, dvd_reg[WIDTH-1]};
    assign fits      = (rem_shift >= {1'b0, divisor_reg});
    assign rem_sub   = rem_shift[WIDTH-1:0] - divisor_reg;
    assign rem_new   = fits ? rem_sub : rem_shift[WIDTH-1:0];
    assign dvd_new   = {dvd_reg[WIDTH-2:0], fits};

    always_comb begin
        state_next   = state_reg;
        dvd_next     = dvd_reg;
        divisor_next = divisor_reg;
        rem_next     = rem_reg;
        count_next   = count_reg;
        q_next       = q_reg;
        r_next       = r_reg;
        done_next    = 1'b0;
        busy_next    = busy_reg;
        dbz_next     = dbz_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    dvd_next     = a;
                    divisor_next = b;
                    rem_next     = '0;
                    dbz_next     = 1'b0;
                    if (b == '0) begin
                        q_next     = '1;
                        r_next     = a;
                        dbz_next   = 1'b1;
                        done_next  = 1'b1;
                        count_next = '0;
                        state_next = DONE;
                    end else begin
                        count_next = CW'(WIDTH);
                        busy_next  = 1'b1;
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                rem_next   = rem_new;
                dvd_next   = dvd_new;
                count_next = count_reg - CW'(1);
                if (count_reg == CW'(1)) begin
                    q_next     = dvd_new;
                    r_next     = rem_new;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            dvd_reg     <= '0;
            divisor_reg <= '0;
            rem_reg     <= '0;
            count_reg   <= '0;
            q_reg       <= '0;
            r_reg       <= '0;
            done_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            dbz_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            dvd_reg     <= dvd_next;
            divisor_reg <= divisor_next;
            rem_reg     <= rem_next;
            count_reg   <= count_next;
            q_reg       <= q_next;
            r_reg       <= r_next;
            done_reg    <= done_next;
            busy_reg    <= busy_next;
            dbz_reg     <= dbz_next;
        end
    end

    assign q           = q_reg;
    assign r           = r_reg;
    assign done        = done_reg;
    assign busy        = busy_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: a WIDTH=4 instance for handshake corner cases and a
// WIDTH=8 instance swept over a grid of operands against the / and % operators.
module tb_seq_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start4;
    logic [3:0] a4, b4, q4, r4;
    logic       done4, busy4, dbz4;
    logic       start8;
    logic [7:0] a8, b8, q8, r8;
    logic       done8, busy8, dbz8;

    int checks   = 0;
    int failures = 0;

    seq_divider #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .q(q4), .r(r4), .done(done4), .busy(busy4), .div_by_zero(dbz4)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .q(q8), .r(r8), .done(done8), .busy(busy8), .div_by_zero(dbz8)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issues one division from an IDLE cycle and returns in the following IDLE cycle.
    // poke pulses an ignored start with different operands while the divider is busy.
    task automatic div4(input logic [3:0] av, input logic [3:0] bv,
                        input logic [3:0] eq, input logic [3:0] er,
                        input logic edbz, input bit poke);
        int n;
        start4 = 1'b1; a4 = av; b4 = bv;
        @(posedge clk); #1;
        start4 = 1'b0;
        n = 0;
        while (!done4 && n < 20) begin
            check_eq("busy4", 32'(busy4), 1);
            if (poke && n == 1) begin
                start4 = 1'b1; a4 = 4'd15; b4 = 4'd5;
            end else begin
                start4 = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start4 = 1'b0;
        check_eq("latency4", n, (bv == 4'd0) ? 0 : 4);
        check_eq("q4", 32'(q4), 32'(eq));
        check_eq("r4", 32'(r4), 32'(er));
        check_eq("dbz4", 32'(dbz4), 32'(edbz));
        check_eq("busy4_done", 32'(busy4), 0);
        $display("div4 %0d/%0d -> q=%0d r=%0d dbz=%0d after %0d cycles", av, bv, q4, r4, dbz4, n);
        @(posedge clk); #1;
        check_eq("pulse4", 32'(done4), 0);
    endtask

    task automatic div8(input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] eq, input logic [7:0] er, input logic edbz);
        int n;
        start8 = 1'b1; a8 = av; b8 = bv;
        @(posedge clk); #1;
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 30) begin
            check_eq("busy8", 32'(busy8), 1);
            @(posedge clk); #1;
            n++;
        end
        check_eq("latency8", n, (bv == 8'd0) ? 0 : 8);
        check_eq("q8", 32'(q8), 32'(eq));
        check_eq("r8", 32'(r8), 32'(er));
        check_eq("dbz8", 32'(dbz8), 32'(edbz));
        $display("div8 %0d/%0d -> q=%0d r=%0d dbz=%0d after %0d cycles", av, bv, q8, r8, dbz8, n);
        @(posedge clk); #1;
        check_eq("pulse8", 32'(done8), 0);
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        #8;
        check_eq("rst_q", 32'(q4), 0);
        check_eq("rst_r", 32'(r4), 0);
        check_eq("rst_done", 32'(done4), 0);
        check_eq("rst_busy", 32'(busy4), 0);
        check_eq("rst_dbz", 32'(dbz4), 0);
        #4 rst = 1'b0;
        @(posedge clk); #1;

        div4(4'd13, 4'd4, 4'd3, 4'd1, 1'b0, 1'b0);
        div4(4'd3, 4'd7, 4'd0, 4'd3, 1'b0, 1'b0);
        div4(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 1'b0);
        div4(4'd9, 4'd0, 4'hF, 4'd9, 1'b1, 1'b0);
        div4(4'd10, 4'd3, 4'd3, 4'd1, 1'b0, 1'b0);
        div4(4'd10, 4'd3, 4'd3, 4'd1, 1'b0, 1'b1);

        // Abort mid-calculation: reset lands between clock edges.
        start4 = 1'b1; a4 = 4'd14; b4 = 4'd3;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("pre_abort_busy", 32'(busy4), 1);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_q", 32'(q4), 0);
        check_eq("abort_r", 32'(r4), 0);
        check_eq("abort_busy", 32'(busy4), 0);
        check_eq("abort_done", 32'(done4), 0);
        check_eq("abort_dbz", 32'(dbz4), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done4) seen++;
        end
        check_eq("abort_no_done", seen, 0);
        $display("abort 14/3 mid-calc -> done pulses after reset=%0d", seen);
        div4(4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 1'b0);

        div8(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
        div8(8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
        div8(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        div8(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1);
        for (int ai = 0; ai <= 255; ai += 15) begin
            for (int bi = 1; bi <= 255; bi += 18) begin
                div8(8'(ai), 8'(bi), 8'(ai / bi), 8'(ai % bi), 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
